// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the ID/EX stage.
package pipeline_pkg;

  localparam int unsigned CTRL_W = 16;
  localparam logic [4:0]  REG_X0 = 5'd0;

  // Control flags that decide whether the EX slot holds live work.
  typedef struct packed {
    logic valid;
    logic regwe;
    logic memre;
    logic memwe;
  } ex_bundle_t;

  localparam ex_bundle_t EX_BUBBLE = '{valid: 1'b0, regwe: 1'b0, memre: 1'b0, memwe: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator between the ID instruction and a load sitting in EX.
module load_use_detect (
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_valid,
  input  logic       ex_memRE,
  input  logic [4:0] ex_rd,
  input  logic       ex_flush,
  output logic       load_use
);
  import pipeline_pkg::*;

  logic hit_rs1;
  logic hit_rs2;

  assign hit_rs1  = id_use_rs1 & (id_rs1 == ex_rd);
  assign hit_rs2  = id_use_rs2 & (id_rs2 == ex_rd);
  // A taken branch squashes the ID instruction, so there is nothing to stall for.
  assign load_use = id_valid & ex_valid & ex_memRE & (ex_rd != REG_X0) &
                    (hit_rs1 | hit_rs2) & ~ex_flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and downstream-stall hold.
// Optional perf counters are enabled with `define PERF_CNT_EN.
module id_ex_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = pipeline_pkg::CTRL_W,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_regWE,
  input  logic              id_memRE,
  input  logic              id_memWE,
  input  logic              ex_flush,
  input  logic              mem_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_regWE,
  output logic              ex_memRE,
  output logic              ex_memWE,
  output logic              stall_if_id,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt
);
  import pipeline_pkg::*;

  logic       load_use;
  ex_bundle_t id_ctl;
  ex_bundle_t ctl_q;

  load_use_detect u_load_use_detect (
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_valid   (ctl_q.valid),
    .ex_memRE   (ctl_q.memre),
    .ex_rd      (ex_rd),
    .ex_flush   (ex_flush),
    .load_use   (load_use)
  );

  assign stall_if_id = load_use | mem_stall;

  // Writes to x0 are dropped here so forwarding never sees x0 as a producer.
  always_comb begin
    id_ctl       = EX_BUBBLE;
    id_ctl.valid = id_valid;
    id_ctl.regwe = id_regWE & id_valid & (id_rd != REG_X0);
    id_ctl.memre = id_memRE & id_valid;
    id_ctl.memwe = id_memWE & id_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_q <= EX_BUBBLE;
    end else if (ex_flush) begin
      ctl_q <= EX_BUBBLE;
    end else if (!mem_stall) begin
      ctl_q <= load_use ? EX_BUBBLE : id_ctl;
    end
  end

  // Data fields only move on a real advance; they are don't-care inside a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_pc       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_ctrl     <= '0;
    end else if (!ex_flush && !mem_stall && !load_use) begin
      ex_pc       <= id_pc;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_ctrl     <= id_ctrl;
    end
  end

  assign ex_valid = ctl_q.valid;
  assign ex_regWE = ctl_q.regwe;
  assign ex_memRE = ctl_q.memre;
  assign ex_memWE = ctl_q.memwe;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             stall_inc;

  assign stall_inc = load_use & ~mem_stall & ~ex_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (ex_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule
